// File: rtl/user_ip_apb_arb_if.sv
// -----------------------------------------------------------------------------
// apb4_if
// APB4 signal bundle shared by one master and one slave.
//
// Signals:
//   psel, penable, pwrite   master -> slave, phase and direction
//   paddr[31:0]             master -> slave, byte address
//   pwdata[31:0]            master -> slave, write data
//   pready                  slave -> master, ends the ACCESS phase
//   prdata[31:0]            slave -> master, read data (valid with pready)
//   pslverr                 slave -> master, error flag (valid with pready)
// -----------------------------------------------------------------------------
interface apb4_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/user_ip_apb_arb.sv
// -----------------------------------------------------------------------------
// user_ip_apb_arb
// Round-robin arbiter letting NREQ requesters share one APB4 slave. The
// winning request is latched in IDLE, run through SETUP/ACCESS on the APB
// bus, and completed with a one-cycle ack pulse in DONE. An ACCESS phase that
// sees no pready for TMO_CYC cycles is aborted and reported as an error.
//
// Parameters:
//   NREQ      number of requesters (2..4)
//   BASE_ADDR slot base OR-ed into every paddr
//   TMO_CYC   ACCESS cycles without pready before abort (0 = never)
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   req_i    per-requester request, held until its ack
//   addr_i   per-requester 8-bit register offset, slice k = [8k+7:8k]
//   wr_i     per-requester direction, 1 = write
//   wdata_i  per-requester 32-bit write data, slice k = [32k+31:32k]
//   ack_o    one-cycle completion pulse to the granted requester
//   err_o    valid with ack_o: slave error or timeout
//   rdata_o  valid with ack_o: read data, 0 on writes and errors
//   apb      APB4 master port
//
// Handshake: a requester raises req_i together with its addr/wr/wdata and
// keeps it high; once granted, the fields are latched and later changes are
// ignored. The transfer ends with ack_o (plus err_o/rdata_o) high for exactly
// one cycle. On the APB side a transfer completes in the first ACCESS cycle
// in which pready is sampled high; pready/pslverr are ignored in other states.
// -----------------------------------------------------------------------------
module user_ip_apb_arb #(
    parameter int          NREQ      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] TMO_CYC   = 16'd255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*8-1:0]  addr_i,
    input  logic [NREQ-1:0]    wr_i,
    input  logic [NREQ*32-1:0] wdata_i,
    output logic [NREQ-1:0]    ack_o,
    output logic               err_o,
    output logic [31:0]        rdata_o,
    apb4_if.master             apb
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0]   NREQ_W     = (IW+1)'(NREQ);
    localparam logic [IW-1:0] LAST_RESET = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   grant_q;
    logic [7:0]      addr_q;
    logic            wr_q;
    logic [31:0]     wdata_q;
    logic [15:0]     cnt_q;
    logic            psel_q;
    logic            penable_q;
    logic [NREQ-1:0] ack_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    // Round-robin winner: scan from last_q+1 upward, wrapping at NREQ.
    logic [IW-1:0]   win_d;
    logic            found_d;
    logic [IW:0]     idx_d;

    always_comb begin
        win_d   = '0;
        found_d = 1'b0;
        idx_d   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_d = {1'b0, last_q} + (IW+1)'(i);
            if (idx_d >= NREQ_W) begin
                idx_d = idx_d - NREQ_W;
            end
            if (!found_d && req_i[idx_d[IW-1:0]]) begin
                found_d = 1'b1;
                win_d   = idx_d[IW-1:0];
            end
        end
    end

    logic tmo_hit;
    assign tmo_hit = (TMO_CYC != 16'd0) && (cnt_q == TMO_CYC);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= LAST_RESET;
            grant_q   <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q <= win_d;
                        addr_q  <= addr_i[win_d*8 +: 8];
                        wr_q    <= wr_i[win_d];
                        wdata_q <= wdata_i[win_d*32 +: 32];
                        cnt_q   <= '0;
                        psel_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        ack_q     <= {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
                        err_q     <= apb.pslverr;
                        rdata_q   <= (!wr_q && !apb.pslverr) ? apb.prdata : 32'd0;
                        last_q    <= grant_q;
                        state_q   <= DONE;
                    end else if (tmo_hit) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        ack_q     <= {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
                        err_q     <= 1'b1;
                        rdata_q   <= 32'd0;
                        last_q    <= grant_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Address/data are only presented while psel is high; zero otherwise.
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = psel_q & wr_q;
    assign apb.paddr   = psel_q ? (BASE_ADDR | {24'd0, addr_q}) : 32'd0;
    assign apb.pwdata  = psel_q ? wdata_q : 32'd0;

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_user_ip_apb_arb.sv
module tb_user_ip_apb_arb;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] addr;
    logic [1:0]  wr;
    logic [63:0] wdata;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;

    apb4_if apb_bus ();

    user_ip_apb_arb #(
        .NREQ      (2),
        .BASE_ADDR (BASE),
        .TMO_CYC   (16'd4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .addr_i  (addr),
        .wr_i    (wr),
        .wdata_i (wdata),
        .ack_o   (ack),
        .err_o   (err),
        .rdata_o (rdata),
        .apb     (apb_bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " psel"},    {31'd0, apb_bus.psel},    32'd0);
        chk({tag, " penable"}, {31'd0, apb_bus.penable}, 32'd0);
        chk({tag, " paddr"},   apb_bus.paddr,            32'd0);
        chk({tag, " pwdata"},  apb_bus.pwdata,           32'd0);
        chk({tag, " ack"},     {30'd0, ack},             32'd0);
        chk({tag, " err"},     {31'd0, err},             32'd0);
        chk({tag, " rdata"},   rdata,                    32'd0);
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;      // ACCESS cycles with pready low before pready high
        logic        slverr;
        logic [31:0] prdata;
        logic        noise;      // pready/pslverr high outside ACCESS
        logic        scramble;   // change req and fields right after grant
        logic [1:0]  exp_ack;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_ack_cyc;
    } vec_t;

    vec_t vecs[9];

    // Run one single-requester transfer starting at a negedge in IDLE (cycle 0).
    task automatic run_txn(input vec_t v, input int id);
        int r;
        logic [31:0] exp_paddr;
        string tag;
        r = (v.exp_ack == 2'b10) ? 1 : 0;
        exp_paddr = BASE | {24'd0, v.addr};
        tag = $sformatf("v%0d", id);
        req   = v.req;
        addr  = r ? {v.addr, ~v.addr} : {~v.addr, v.addr};
        wr    = r ? {v.wr, ~v.wr} : {~v.wr, v.wr};
        wdata = r ? {v.wdata, ~v.wdata} : {~v.wdata, v.wdata};
        apb_bus.pready  = v.noise;
        apb_bus.pslverr = v.noise;
        apb_bus.prdata  = 32'hBAD0_BAD0;
        for (int k = 1; k <= v.exp_ack_cyc + 1; k++) begin
            @(negedge clk);
            if (k < v.exp_ack_cyc) begin
                chk({tag, " psel"},    {31'd0, apb_bus.psel},    32'd1);
                chk({tag, " penable"}, {31'd0, apb_bus.penable}, (k >= 2) ? 32'd1 : 32'd0);
                chk({tag, " paddr"},   apb_bus.paddr,            exp_paddr);
                chk({tag, " pwrite"},  {31'd0, apb_bus.pwrite},  {31'd0, v.wr});
                chk({tag, " pwdata"},  apb_bus.pwdata,           v.wdata);
                chk({tag, " ack_early"}, {30'd0, ack},           32'd0);
            end else if (k == v.exp_ack_cyc) begin
                chk({tag, " ack"},     {30'd0, ack},             {30'd0, v.exp_ack});
                chk({tag, " err"},     {31'd0, err},             {31'd0, v.exp_err});
                chk({tag, " rdata"},   rdata,                    v.exp_rdata);
                chk({tag, " psel_done"}, {31'd0, apb_bus.psel},  32'd0);
                chk({tag, " paddr_done"}, apb_bus.paddr,         32'd0);
            end else begin
                chk_idle_outputs({tag, " after"});
            end
            // drive slave and requester for the current cycle
            if (v.scramble && k == 1) begin
                req   = 2'b00;
                addr  = ~addr;
                wr    = ~wr;
                wdata = ~wdata;
            end
            if (k >= v.exp_ack_cyc) begin
                req = 2'b00;
            end
            if (k >= 2 && k < v.exp_ack_cyc && (k - 2) == v.waits) begin
                apb_bus.pready  = 1'b1;
                apb_bus.pslverr = v.slverr;
                apb_bus.prdata  = v.prdata;
            end else if (k >= 2 && k < v.exp_ack_cyc) begin
                apb_bus.pready  = 1'b0;
                apb_bus.pslverr = 1'b0;
                apb_bus.prdata  = 32'hBAD0_BAD0;
            end else begin
                apb_bus.pready  = v.noise;
                apb_bus.pslverr = v.noise;
                apb_bus.prdata  = 32'hBAD0_BAD0;
            end
        end
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
    endtask

    logic [1:0]  exp_q[$];
    logic [31:0] wd [2];

    initial begin
        //               req    addr   wr    wdata          waits slverr prdata        noise scr  ack    err   rdata         cyc
        vecs[0] = '{2'b01, 8'h04, 1'b0, 32'h0000_0000, 0,  1'b0, 32'h0000_00A5, 1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_00A5, 3};
        vecs[1] = '{2'b10, 8'h3C, 1'b1, 32'hDEAD_BEEF, 0,  1'b0, 32'h0000_1234, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 3};
        vecs[2] = '{2'b01, 8'h18, 1'b1, 32'h0BAD_F00D, 3,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0000, 6};
        vecs[3] = '{2'b10, 8'hF0, 1'b0, 32'h1111_2222, 2,  1'b0, 32'h0000_55AA, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_55AA, 5};
        vecs[4] = '{2'b01, 8'h08, 1'b0, 32'h0000_0000, 0,  1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 3};
        vecs[5] = '{2'b10, 8'h0C, 1'b0, 32'h0000_0000, 99, 1'b0, 32'hCAFE_CAFE, 1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_0000, 7};
        vecs[6] = '{2'b01, 8'h77, 1'b0, 32'h0000_0000, 0,  1'b0, 32'h0000_0077, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0077, 3};
        vecs[7] = '{2'b10, 8'h5A, 1'b1, 32'hA5A5_5A5A, 1,  1'b0, 32'h0000_0000, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 4};
        vecs[8] = '{2'b01, 8'hFF, 1'b1, 32'h8000_0001, 0,  1'b1, 32'h0000_0000, 1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 3};

        // reset block
        rst   = 1'b1;
        req   = 2'b00;
        addr  = '0;
        wr    = '0;
        wdata = '0;
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        apb_bus.prdata  = 32'd0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        apb_bus.pready  = 1'b1;
        apb_bus.pslverr = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset_noise");
        apb_bus.pready  = 1'b0;
        apb_bus.pslverr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        // table-driven single transfers
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], i);
        end

        // contention: both requesting writes continuously from reset
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("cont_reset");
        rst = 1'b0;
        wd[0] = 32'h0000_1111;
        wd[1] = 32'h2222_0000;
        req   = 2'b11;
        wr    = 2'b11;
        addr  = {8'h20, 8'h10};
        wdata = {wd[1], wd[0]};
        apb_bus.pready = 1'b1;
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        for (int k = 1; k <= 16; k++) begin
            int ph;
            int who;
            logic [1:0] ea;
            @(negedge clk);
            ph  = (k - 1) % 4;
            who = ((k - 1) / 4) % 2;
            chk($sformatf("cont%0d psel", k), {31'd0, apb_bus.psel}, (ph < 2) ? 32'd1 : 32'd0);
            chk($sformatf("cont%0d pwdata", k), apb_bus.pwdata, (ph < 2) ? wd[who] : 32'd0);
            if (ph == 2) begin
                ea = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
                chk($sformatf("cont%0d ack", k), {30'd0, ack}, {30'd0, ea});
            end else begin
                chk($sformatf("cont%0d ack_idle", k), {30'd0, ack}, 32'd0);
            end
            if (k == 15) req = 2'b00;
        end
        chk("cont exp_q empty", exp_q.size(), 32'd0);

        // reset during ACCESS: last grant 0 so requester 1 wins first
        apb_bus.pready = 1'b0;
        run_txn(vecs[0], 100);
        req   = 2'b11;
        wr    = 2'b00;
        addr  = {8'h88, 8'h44};
        wdata = {32'h0000_0002, 32'h0000_0001};
        apb_bus.pready = 1'b1;
        apb_bus.prdata = 32'h0000_1234;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            case (k)
                1: chk("rst_acc grant1 paddr", apb_bus.paddr, BASE | 32'h88);
                2: begin
                    chk("rst_acc penable", {31'd0, apb_bus.penable}, 32'd1);
                    rst = 1'b1;
                end
                3: begin
                    chk("rst_acc psel dropped", {31'd0, apb_bus.psel}, 32'd0);
                    chk("rst_acc no ack3", {30'd0, ack}, 32'd0);
                    rst = 1'b0;
                end
                4: begin
                    chk("rst_acc regrant psel", {31'd0, apb_bus.psel}, 32'd1);
                    chk("rst_acc regrant paddr", apb_bus.paddr, BASE | 32'h44);
                    chk("rst_acc no ack4", {30'd0, ack}, 32'd0);
                end
                5: chk("rst_acc no ack5", {30'd0, ack}, 32'd0);
                6: begin
                    chk("rst_acc ack", {30'd0, ack}, 32'd1);
                    chk("rst_acc rdata", rdata, 32'h0000_1234);
                    chk("rst_acc err", {31'd0, err}, 32'd0);
                    req = 2'b00;
                end
                default: chk("rst_acc ack gone", {30'd0, ack}, 32'd0);
            endcase
        end
        apb_bus.pready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/user_ip_apb_arb.md
USER_IP_APB_ARB -- requirements
Module: user_ip_apb_arb

Interface
REQ-001 The module SHALL have parameter NREQ, default 2, meaning the number of requesters sharing one user-IP APB slave (legal range 2..4).
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the slot base OR-ed into every paddr.
REQ-003 The module SHALL have parameter TMO_CYC, default 16'd255, meaning the ACCESS-phase cycles without pready before abort.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port req_i, input, NREQ bits: per-requester transfer request, held high until the matching ack_o.
REQ-007 The module SHALL have port addr_i, input, NREQ*8 bits: per-requester register offset, slice k = [8k+7:8k].
REQ-008 The module SHALL have port wr_i, input, NREQ bits: per-requester direction, 1 = write.
REQ-009 The module SHALL have port wdata_i, input, NREQ*32 bits: per-requester write data.
REQ-010 The module SHALL have port ack_o, output, NREQ bits: one-cycle completion pulse to the granted requester.
REQ-011 The module SHALL have port err_o, output, 1 bit: valid with ack_o; 1 = pslverr or timeout.
REQ-012 The module SHALL have port rdata_o, output, 32 bits: valid with ack_o; read data, 0 on writes and errors.
REQ-013 The module SHALL have port apb, an apb4_if.master interface (psel, penable, pwrite, paddr[31:0], pwdata[31:0], pready, prdata, pslverr).

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, ACCESS, DONE.
REQ-015 IDLE with any req_i bit high SHALL latch the winner's index, addr, wr and wdata, then move to SETUP; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 has priority first.
REQ-017 last_grant SHALL update on entry to DONE.
REQ-018 SETUP SHALL drive psel=1 and penable=0, then move to ACCESS unconditionally.
REQ-019 ACCESS SHALL drive psel=1 and penable=1.
REQ-020 paddr SHALL equal BASE_ADDR | {24'd0, latched addr}; pwrite and pwdata SHALL come from the latched values, stable from SETUP through ACCESS.
REQ-021 psel, penable, paddr, pwrite and pwdata SHALL be 0 in IDLE and DONE.
REQ-022 ACCESS with pready=1 SHALL capture prdata (reads only) and pslverr, then move to DONE.
REQ-023 ACCESS SHALL count the cycles with pready=0 in a 16-bit counter cleared on entry to SETUP.
REQ-024 When that counter equals TMO_CYC while pready=0, the FSM SHALL move to DONE with err=1 and rdata=0; TMO_CYC=0 SHALL disable the timeout.
REQ-025 DONE SHALL assert ack_o[grant] for exactly one cycle with err_o and rdata_o, then return to IDLE.
REQ-026 err_o and rdata_o SHALL be 0 outside DONE.
REQ-027 Latency with zero-wait slave: req_i high in cycle 0 (IDLE) -> SETUP cycle 1, ACCESS cycle 2, ack_o cycle 3, IDLE cycle 4; throughput SHALL be one transfer per 4 cycles minimum.
REQ-028 Changes to req_i or request fields after grant SHALL be ignored; the latched transfer SHALL complete and ack SHALL still pulse.
REQ-029 Simultaneous requests SHALL each be granted exactly once per round-robin cycle; no requester SHALL wait more than NREQ-1 other transfers.
REQ-030 pready or pslverr outside ACCESS SHALL be ignored.

Reset
REQ-031 rst_i high at a clock edge SHALL force IDLE, last_grant=NREQ-1, counter=0 and all latched fields=0.
REQ-032 During and after reset, all apb outputs, ack_o, err_o and rdata_o SHALL be 0.
REQ-033 Reset mid-transfer SHALL drop psel the next cycle and SHALL NOT produce an ack for the aborted transfer.

Verification
REQ-034 Single read: req_i=2'b01, addr0=8'h04, wr=0, slave pready=1, prdata=32'hA5 -> paddr=32'h04 in cycles 1-2, ack_o=2'b01 in cycle 3, rdata_o=32'hA5, err_o=0.
REQ-035 Contention: req_i=2'b11 held continuously, writes -> grant order 0,1,0,1; acks in cycles 3,7,11,15; pwdata matches each requester.
REQ-036 Wait states: pready low for 3 ACCESS cycles -> ack_o in cycle 6; paddr, pwrite and pwdata stable from cycle 1 through cycle 5.
REQ-037 Timeout: TMO_CYC=4, pready stuck 0 -> ack_o with err_o=1 and rdata_o=0 in cycle 7; psel=0 from cycle 7.
REQ-038 Slave error: pslverr=1 with pready=1 on a read -> err_o=1, rdata_o=0.
REQ-039 Reset in ACCESS: rst_i pulsed in cycle 2 -> psel=0 in cycle 3, no ack_o; next request is granted to requester 0.
